// File: rtl/pcw_boot_pkg.sv
// pcw_boot_pkg
// Shared definitions for the boot copier: the boot image length and the
// copier state encoding. Imported by boot_copier.
package pcw_boot_pkg;

   // Number of bytes in the boot ROM image that must reach RAM
   localparam int unsigned BOOT_LEN = 275;

   // Copier sequencing states
   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WRITE,
      FINISH
   } boot_state_e;

   // Modulo-256 running sum used for the copy checksum
   function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

endpackage

// File: rtl/boot_copier.sv
// boot_copier
// Copies LENGTH bytes from an external boot ROM into RAM starting at RAM_BASE,
// holding the CPU in reset until the copy has finished.
//
// Ports:
//   clk_sys   in   system clock, rising edge
//   reset_n   in   asynchronous active-low reset
//   start     in   single-cycle copy request (honoured in IDLE and FINISH)
//   rom_addr  out  boot ROM read address, always equal to the byte counter
//   rom_data  in   combinational ROM data for rom_addr
//   ram_addr  out  RAM write address (RAM_BASE + count, wraps at RAM_AW bits)
//   ram_dout  out  RAM write data
//   ram_we    out  RAM write request, held until ram_ready accepts it
//   ram_ready in   RAM accepts the write when ram_we and ram_ready are both 1
//   cpu_hold  out  keeps the CPU in reset while 1
//   done      out  copy complete
//   checksum  out  modulo-256 sum of every byte accepted by RAM
module boot_copier
   import pcw_boot_pkg::*;
#(
   parameter int unsigned LENGTH   = BOOT_LEN,
   parameter int unsigned RAM_AW   = 19,
   parameter int unsigned RAM_BASE = 0
) (
   input  logic              clk_sys,
   input  logic              reset_n,
   input  logic              start,
   output logic [8:0]        rom_addr,
   input  logic [7:0]        rom_data,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [7:0]        ram_dout,
   output logic              ram_we,
   input  logic              ram_ready,
   output logic              cpu_hold,
   output logic              done,
   output logic [7:0]        checksum
);

   // Counter value of the final byte; LENGTH is limited to 1..512
   localparam logic [8:0]        LAST = 9'(LENGTH - 1);
   // Base address truncated to the RAM width so address arithmetic wraps
   localparam logic [RAM_AW-1:0] BASE = RAM_AW'(RAM_BASE);

   boot_state_e state;
   logic [8:0]  count;

   // The ROM is addressed straight from the counter, so the data for the
   // byte being fetched is already valid during the FETCH cycle.
   assign rom_addr = count;

   // Single sequencing process; every output except rom_addr is a register,
   // so ram_we never depends combinationally on ram_ready.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         count    <= '0;
         checksum <= '0;
         ram_we   <= 1'b0;
         done     <= 1'b0;
         cpu_hold <= 1'b1;
         ram_addr <= BASE;
         ram_dout <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state    <= FETCH;
                  count    <= '0;
                  checksum <= '0;
               end
            end

            FETCH: begin
               // Capture address and data together; they stay frozen for
               // however long the RAM stalls the write.
               ram_addr <= BASE + RAM_AW'(count);
               ram_dout <= rom_data;
               ram_we   <= 1'b1;
               state    <= WRITE;
            end

            WRITE: begin
               if (ram_ready) begin
                  ram_we   <= 1'b0;
                  checksum <= sum8(checksum, ram_dout);
                  if (count == LAST) begin
                     state    <= FINISH;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     count <= count + 9'd1;
                     state <= FETCH;
                  end
               end
            end

            FINISH: begin
               // A new start re-runs the whole copy with the CPU held again
               if (start) begin
                  state    <= FETCH;
                  count    <= '0;
                  checksum <= '0;
                  done     <= 1'b0;
                  cpu_hold <= 1'b1;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_boot_copier.sv
// tb_boot_copier
// Directed self-checking bench for boot_copier. Three instances share one
// clock: A uses the full-length boot image, B a 4-byte stub that wraps the RAM
// address, C a single-byte copy. Accepted RAM writes are logged per instance.
module tb_boot_copier;

   logic clk;

   // Instance A: LENGTH from the package default, RAM_BASE 0
   logic        a_rst_n, a_start, a_ready, a_we, a_hold, a_done;
   logic [8:0]  a_rom_addr;
   logic [7:0]  a_rom_data, a_dout, a_csum;
   logic [18:0] a_ram_addr;

   // Instance B: LENGTH 4, RAM_BASE 0x7FFFE
   logic        b_rst_n, b_start, b_ready, b_we, b_hold, b_done;
   logic [8:0]  b_rom_addr;
   logic [7:0]  b_rom_data, b_dout, b_csum;
   logic [18:0] b_ram_addr;

   // Instance C: LENGTH 1
   logic        c_rst_n, c_start, c_ready, c_we, c_hold, c_done;
   logic [8:0]  c_rom_addr;
   logic [7:0]  c_rom_data, c_dout, c_csum;
   logic [18:0] c_ram_addr;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   // Write logs
   logic [18:0] a_log_addr [2048];
   logic [7:0]  a_log_data [2048];
   int          a_nwr = 0;
   logic [18:0] b_log_addr [256];
   logic [7:0]  b_log_data [256];
   int          b_nwr = 0;
   logic [18:0] c_log_addr [256];
   logic [7:0]  c_log_data [256];
   int          c_nwr = 0;

   // Boot image stand-in: fixed head and tail bytes, arbitrary filler between
   function automatic logic [7:0] rom_a(input logic [8:0] addr);
      case (addr)
         9'd0:    return 8'hC3;
         9'd1:    return 8'h02;
         9'd2:    return 8'h01;
         9'd3:    return 8'hF3;
         9'd272:  return 8'hC3;
         9'd273:  return 8'h00;
         9'd274:  return 8'h00;
         default: return 8'((addr * 7) + 3);
      endcase
   endfunction

   function automatic logic [7:0] rom_b(input logic [8:0] addr);
      case (addr)
         9'd0:    return 8'h10;
         9'd1:    return 8'h20;
         9'd2:    return 8'h30;
         9'd3:    return 8'hF0;
         default: return 8'h00;
      endcase
   endfunction

   assign a_rom_data = rom_a(a_rom_addr);
   assign b_rom_data = rom_b(b_rom_addr);
   assign c_rom_data = (c_rom_addr == 9'd0) ? 8'h5A : 8'hEE;

   boot_copier u_a (
      .clk_sys   (clk),
      .reset_n   (a_rst_n),
      .start     (a_start),
      .rom_addr  (a_rom_addr),
      .rom_data  (a_rom_data),
      .ram_addr  (a_ram_addr),
      .ram_dout  (a_dout),
      .ram_we    (a_we),
      .ram_ready (a_ready),
      .cpu_hold  (a_hold),
      .done      (a_done),
      .checksum  (a_csum)
   );

   boot_copier #(.LENGTH(4), .RAM_AW(19), .RAM_BASE(32'h7FFFE)) u_b (
      .clk_sys   (clk),
      .reset_n   (b_rst_n),
      .start     (b_start),
      .rom_addr  (b_rom_addr),
      .rom_data  (b_rom_data),
      .ram_addr  (b_ram_addr),
      .ram_dout  (b_dout),
      .ram_we    (b_we),
      .ram_ready (b_ready),
      .cpu_hold  (b_hold),
      .done      (b_done),
      .checksum  (b_csum)
   );

   boot_copier #(.LENGTH(1), .RAM_AW(19), .RAM_BASE(0)) u_c (
      .clk_sys   (clk),
      .reset_n   (c_rst_n),
      .start     (c_start),
      .rom_addr  (c_rom_addr),
      .rom_data  (c_rom_data),
      .ram_addr  (c_ram_addr),
      .ram_dout  (c_dout),
      .ram_we    (c_we),
      .ram_ready (c_ready),
      .cpu_hold  (c_hold),
      .done      (c_done),
      .checksum  (c_csum)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every accepted write
   always @(posedge clk) begin
      if (a_we && a_ready && a_nwr < 2048) begin
         a_log_addr[a_nwr] = a_ram_addr;
         a_log_data[a_nwr] = a_dout;
         a_nwr++;
      end
      if (b_we && b_ready && b_nwr < 256) begin
         b_log_addr[b_nwr] = b_ram_addr;
         b_log_data[b_nwr] = b_dout;
         b_nwr++;
      end
      if (c_we && c_ready && c_nwr < 256) begin
         c_log_addr[c_nwr] = c_ram_addr;
         c_log_data[c_nwr] = c_dout;
         c_nwr++;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   int          n;
   int          base;
   int          bad;
   int          hits;
   logic        hold_prev;
   logic [7:0]  model_sum;

   initial begin
      a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
      a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
      a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1;
      model_sum = 8'h00;
      for (int i = 0; i < 275; i++) model_sum = model_sum + rom_a(9'(i));

      repeat (3) tick();

      // Reset state
      check("rst_rom_addr", a_rom_addr, 0);
      check("rst_we", a_we, 0);
      check("rst_hold", a_hold, 1);
      check("rst_done", a_done, 0);
      check("rst_csum", a_csum, 0);
      check("rst_ram_addr", a_ram_addr, 0);
      check("rst_dout", a_dout, 0);
      check("rst_b_ram_addr", b_ram_addr, 32'h7FFFE);

      a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
      repeat (2) tick();
      check("idle_hold", a_hold, 1);

      // A: full boot copy
      base = a_nwr;
      a_start = 1'b1; tick(); a_start = 1'b0;
      n = 0; hold_prev = 1'b0;
      while (!a_done && n < 2000) begin hold_prev = a_hold; tick(); n++; end
      check("a1_latency", n, 550);
      check("a1_hold_prev", hold_prev, 1);
      check("a1_hold_fall", a_hold, 0);
      check("a1_writes", a_nwr - base, 275);
      bad = 0;
      for (int i = 0; i < 275; i++) begin
         if (a_log_addr[base + i] !== 19'(i)) bad++;
         if (a_log_data[base + i] !== rom_a(9'(i))) bad++;
      end
      check("a1_log_bad", bad, 0);
      check("a1_d0", a_log_data[base + 0], 32'hC3);
      check("a1_d1", a_log_data[base + 1], 32'h02);
      check("a1_d2", a_log_data[base + 2], 32'h01);
      check("a1_d3", a_log_data[base + 3], 32'hF3);
      check("a1_d272", a_log_data[base + 272], 32'hC3);
      check("a1_d274", a_log_data[base + 274], 32'h00);
      check("a1_csum", a_csum, model_sum);
      check("a1_rom_addr_fin", a_rom_addr, 274);
      check("a1_we_fin", a_we, 0);

      // A: re-copy from FINISH, with stray starts in WRITE and FETCH
      base = a_nwr;
      a_start = 1'b1; tick(); a_start = 1'b0;
      check("a2_csum_clr", a_csum, 0);
      check("a2_done_clr", a_done, 0);
      check("a2_hold_set", a_hold, 1);
      n = 0;
      tick(); n++;
      check("a2_in_write", a_we, 1);
      a_start = 1'b1; tick(); n++;
      tick(); n++; a_start = 1'b0;
      while (!a_done && n < 2000) begin tick(); n++; end
      check("a2_latency", n, 550);
      check("a2_writes", a_nwr - base, 275);
      check("a2_csum", a_csum, model_sum);

      // A: reset in the middle of byte 100
      base = a_nwr;
      a_start = 1'b1; tick(); a_start = 1'b0;
      repeat (201) tick();
      check("a3_we_b100", a_we, 1);
      check("a3_addr_b100", a_ram_addr, 100);
      check("a3_writes_pre", a_nwr - base, 100);
      a_rst_n = 1'b0;
      #1;
      check("a3_rst_we", a_we, 0);
      check("a3_rst_hold", a_hold, 1);
      check("a3_rst_addr", a_ram_addr, 0);
      check("a3_rst_rom", a_rom_addr, 0);
      repeat (3) tick();
      a_rst_n = 1'b1;
      repeat (6) tick();
      check("a3_no_writes", a_nwr - base, 100);
      check("a3_idle_we", a_we, 0);
      a_start = 1'b1; tick(); a_start = 1'b0;
      tick();
      check("a3_restart_we", a_we, 1);
      check("a3_restart_addr", a_ram_addr, 0);
      check("a3_restart_dout", a_dout, 32'hC3);
      tick();
      check("a3_restart_writes", a_nwr - base, 101);

      // B: address wrap with the 4-byte stub
      base = b_nwr;
      b_start = 1'b1; tick(); b_start = 1'b0;
      n = 0;
      while (!b_done && n < 100) begin tick(); n++; end
      check("b1_latency", n, 8);
      check("b1_writes", b_nwr - base, 4);
      check("b1_addr0", b_log_addr[base + 0], 32'h7FFFE);
      check("b1_addr1", b_log_addr[base + 1], 32'h7FFFF);
      check("b1_addr2", b_log_addr[base + 2], 32'h00000);
      check("b1_addr3", b_log_addr[base + 3], 32'h00001);
      check("b1_data3", b_log_data[base + 3], 32'hF0);
      check("b1_csum", b_csum, 32'h50);

      // B: re-copy with a 5-cycle stall on byte 2
      base = b_nwr;
      b_start = 1'b1; tick(); b_start = 1'b0;
      n = 0;
      repeat (5) begin tick(); n++; end
      check("b2_write2_we", b_we, 1);
      check("b2_write2_addr", b_ram_addr, 0);
      b_ready = 1'b0;
      repeat (5) begin
         tick(); n++;
         check("b2_stall_we", b_we, 1);
         check("b2_stall_addr", b_ram_addr, 0);
         check("b2_stall_dout", b_dout, 32'h30);
      end
      b_ready = 1'b1;
      while (!b_done && n < 100) begin tick(); n++; end
      check("b2_latency", n, 13);
      check("b2_writes", b_nwr - base, 4);
      hits = 0;
      for (int i = 0; i < 4; i++) if (b_log_addr[base + i] === 19'h0) hits++;
      check("b2_byte2_once", hits, 1);
      check("b2_csum", b_csum, 32'h50);

      // C: single-byte copy
      base = c_nwr;
      c_start = 1'b1; tick(); c_start = 1'b0;
      n = 0;
      while (!c_done && n < 100) begin tick(); n++; end
      check("c_latency", n, 2);
      check("c_writes", c_nwr - base, 1);
      check("c_addr", c_log_addr[base], 0);
      check("c_data", c_log_data[base], 32'h5A);
      check("c_csum", c_csum, 32'h5A);
      check("c_hold", c_hold, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/boot_copier.md
BOOT_COPIER -- requirements
Module: boot_copier

Interface
REQ-001 SHALL have parameter LENGTH, default 275; the number of boot bytes copied.
REQ-002 SHALL have parameter RAM_AW, default 19; the RAM byte-address width.
REQ-003 SHALL have parameter RAM_BASE, default 0; the first RAM destination address.
REQ-004 SHALL have port clk_sys, input, 1 bit; the single system clock; all logic is rising-edge.
REQ-005 SHALL have port reset_n, input, 1 bit; asynchronous active-low reset.
REQ-006 SHALL have port start, input, 1 bit; a single-cycle request to begin a copy.
REQ-007 SHALL have port rom_addr, output, 9 bits; the boot ROM read address.
REQ-008 SHALL have port rom_data, input, 8 bits; combinational ROM data for rom_addr.
REQ-009 SHALL have port ram_addr, output, RAM_AW bits; the RAM write address.
REQ-010 SHALL have port ram_dout, output, 8 bits; the RAM write data.
REQ-011 SHALL have port ram_we, output, 1 bit; a RAM write request.
REQ-012 SHALL have port ram_ready, input, 1 bit; RAM accepts the write on a cycle where ram_we=1 and ram_ready=1.
REQ-013 SHALL have port cpu_hold, output, 1 bit; holds the Z80 in reset while 1.
REQ-014 SHALL have port done, output, 1 bit; the copy has completed.
REQ-015 SHALL have port checksum, output, 8 bits; the modulo-256 sum of all bytes written.

Function
REQ-016 SHALL implement states IDLE, FETCH, WRITE and FINISH.
REQ-017 IDLE: cpu_hold=1, ram_we=0; start=1 -> FETCH, with count=0 and checksum=0.
REQ-018 FETCH (one cycle): rom_addr=count[8:0]; ram_dout and ram_addr=RAM_BASE+count are registered at the clock edge; next state is WRITE.
REQ-019 WRITE: ram_we=1; ram_addr and ram_dout stay stable until accepted; ram_ready=0 holds the state indefinitely.
REQ-020 WRITE acceptance: checksum+=ram_dout (mod 256).
REQ-021 WRITE acceptance with count=LENGTH-1 -> FINISH.
REQ-022 WRITE acceptance otherwise: count+=1 -> FETCH.
REQ-023 Throughput: each byte SHALL take at least 2 cycles; with ram_ready tied high, a full copy takes exactly 2*LENGTH cycles from the cycle after start.
REQ-024 FINISH: done=1, cpu_hold=0, ram_we=0; start=1 -> FETCH with count and checksum cleared (re-copy).
REQ-025 start SHALL be ignored in FETCH and WRITE.
REQ-026 count SHALL be 9 bits; LENGTH SHALL be in the range 1 to 512; LENGTH=1 gives exactly one write, then FINISH.
REQ-027 RAM address arithmetic SHALL truncate to RAM_AW bits, wrapping silently.
REQ-028 rom_addr SHALL equal count at all times, including in IDLE (0 after reset).
REQ-029 ram_we SHALL be registered, with no combinational path from ram_ready.

Reset
REQ-030 reset_n=0 SHALL immediately force the state to IDLE.
REQ-031 reset_n=0 SHALL force count=0, checksum=0, ram_we=0, done=0, cpu_hold=1, ram_addr=RAM_BASE and ram_dout=0.
REQ-032 Reset asserted mid-copy SHALL abort the copy with no further writes; a new start is required after release.

Structure
REQ-033 A shared package pcw_boot_pkg SHALL hold the state enum type and the BOOT_LEN=275 constant; the top level passes BOOT_LEN to LENGTH.
REQ-034 The block SHALL be a single module with no sub-modules; the ROM stays external, driven by rom_addr/rom_data.

Verification
REQ-035 Reset release, start pulse, ram_ready=1, LENGTH=275, full boot ROM -> exactly 275 writes to addresses 0..274, with data matching ROM bytes 0xC3,0x02,0x01,0xF3 first and 0xC3,0x00,0x00 last; done=1 at cycle 550; cpu_hold falls in the same cycle.
REQ-036 LENGTH=4, stub ROM 0x10,0x20,0x30,0xF0, RAM_BASE=0x7FFFE, RAM_AW=19 -> writes to addresses 0x7FFFE, 0x7FFFF, 0x00000, 0x00001; checksum=0x50.
REQ-037 ram_ready low for 5 cycles during byte 2 -> ram_we held, ram_addr and ram_dout stable for the whole stall; only one write recorded for byte 2; total latency increases by 5.
REQ-038 Second start pulse during WRITE -> ignored, write count unchanged; start in FINISH -> full re-copy, checksum recomputed to the same value.
REQ-039 reset_n asserted at byte 100 -> ram_we=0 and cpu_hold=1 in the same cycle, no writes until the next start; the next copy restarts at address RAM_BASE.
REQ-040 LENGTH=1 -> one write of ROM byte 0, then done=1 two cycles after start.
